// File: rtl/ysyx_23060096_lsu_if.sv
// Bus bundle for the load/store unit: EXU request side, data-memory port and WBU result side.
// slave is the LSU's view, master is the view of the surrounding environment.
interface ysyx_23060096_lsu_if #(parameter int ADDR_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic              in_memwr;
    logic              in_memrd;
    logic [2:0]        in_memop;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rdata;
    logic              out_err;

    modport slave (
        input  in_valid, in_memwr, in_memrd, in_memop, in_addr, in_wdata,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
        input  mem_ack, mem_rdata,
        output out_valid, out_rdata, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_memwr, in_memrd, in_memop, in_addr, in_wdata,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
        output mem_ack, mem_rdata,
        input  out_valid, out_rdata, out_err,
        output out_ready
    );
endinterface

// File: rtl/ysyx_23060096_lsu.sv
// Non-pipelined load/store unit: IDLE -> REQ -> RESP, byte/half/word lanes with sign/zero extension.
// Optional misaligned-access trap enabled by defining YSYX_23060096_LSU_MISALIGN_CHECK_EN.
module ysyx_23060096_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_23060096_lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        off_r;
    logic [2:0]        memop_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_wmask_r;
    logic [31:0]       mem_wdata_r;
    logic [31:0]       out_rdata_r;
    logic              out_err_r;

    logic              accept_s;
    logic              access_s;
    logic              misalign_s;
    logic [3:0]        wmask_s;
    logic [31:0]       wdata_s;

    // Lane select and extension of a read word; memop[1:0] picks size, memop[2] means unsigned.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op[1:0])
            2'b00:   r = op[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = op[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Request decode: acceptance, alignment trap and store lane/data formatting.
    always_comb begin
        accept_s   = bus.in_valid & (state_r == IDLE);
        access_s   = bus.in_memwr | bus.in_memrd;
        misalign_s = 1'b0;
`ifdef YSYX_23060096_LSU_MISALIGN_CHECK_EN
        case (bus.in_memop[1:0])
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = access_s & bus.in_addr[0];
            default: misalign_s = access_s & (bus.in_addr[1:0] != 2'b00);
        endcase
`endif
        wmask_s = 4'b0000;
        wdata_s = 32'd0;
        if (bus.in_memwr && !misalign_s) begin
            case (bus.in_memop[1:0])
                2'b00: begin
                    wmask_s = 4'b0001 << bus.in_addr[1:0];
                    wdata_s = {4{bus.in_wdata[7:0]}};
                end
                2'b01: begin
                    wmask_s = 4'b0011 << {bus.in_addr[1], 1'b0};
                    wdata_s = {2{bus.in_wdata[15:0]}};
                end
                default: begin
                    wmask_s = 4'b1111;
                    wdata_s = bus.in_wdata;
                end
            endcase
        end else begin
            wmask_s = 4'b0000;
            wdata_s = 32'd0;
        end
    end

    // Next-state logic; a trapped or no-op request skips the memory phase.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (access_s && !misalign_s) begin
                        state_s = REQ;
                    end else begin
                        state_s = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_s = RESP;
                end else begin
                    state_s = REQ;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Access registers: captured on accept, load result captured on ack; store wins over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            off_r       <= 2'b00;
            memop_r     <= 3'b000;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wmask_r <= 4'b0000;
            mem_wdata_r <= 32'd0;
            out_rdata_r <= 32'd0;
            out_err_r   <= 1'b0;
        end else if (accept_s) begin
            off_r       <= bus.in_addr[1:0];
            memop_r     <= bus.in_memop;
            mem_we_r    <= bus.in_memwr & ~misalign_s;
            mem_addr_r  <= {bus.in_addr[ADDR_W-1:2], 2'b00};
            mem_wmask_r <= wmask_s;
            mem_wdata_r <= wdata_s;
            out_rdata_r <= 32'd0;
            out_err_r   <= misalign_s;
        end else if ((state_r == REQ) && bus.mem_ack) begin
            mem_we_r    <= 1'b0;
            out_rdata_r <= mem_we_r ? 32'd0 : load_ext(bus.mem_rdata, off_r, memop_r);
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.mem_req   = (state_r == REQ);
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wmask = mem_wmask_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.out_valid = (state_r == RESP);
    assign bus.out_rdata = out_rdata_r;
    assign bus.out_err   = out_err_r;

endmodule
